// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-register busy (reservation) bits and a
// one-register-per-cycle clear sweep. Define REGFILE_MP_BYPASS_EN for same-cycle write forwarding.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  clr_req,
    output logic                  ready
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [AW-1:0]          clr_cnt_r;
    logic [AW-1:0]          clr_cnt_nx_s;
    logic                   ready_r;
    logic [NREG-1:0]        busy_r;
    logic [XLEN-1:0]        mem_r [NREG];
    logic                   wr_ok_s;
    logic                   rsv_ok_s;

    assign wr_ok_s  = ready_r & we & (wr_addr != ADDR_ZERO);
    assign rsv_ok_s = ready_r & rsv_en & (rsv_addr != ADDR_ZERO);
    assign ready    = ready_r;

    // Next-state logic: sweep counter in CLEAR, clear request in READY
    always_comb begin
        state_nx_s   = state_r;
        clr_cnt_nx_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == CNT_LAST) begin
                    state_nx_s   = ST_READY;
                    clr_cnt_nx_s = ADDR_ZERO;
                end else begin
                    clr_cnt_nx_s = clr_cnt_r + CNT_ONE;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nx_s   = ST_CLEAR;
                    clr_cnt_nx_s = ADDR_ZERO;
                end else begin
                    clr_cnt_nx_s = ADDR_ZERO;
                end
            end
            default: begin
                state_nx_s   = ST_CLEAR;
                clr_cnt_nx_s = ADDR_ZERO;
            end
        endcase
    end

    // State, sweep counter and ready flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= ADDR_ZERO;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            clr_cnt_r <= clr_cnt_nx_s;
            ready_r   <= (state_nx_s == ST_READY);
        end
    end

    // Register array: no reset, zeroed by the sweep instead
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= {XLEN{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Busy bits; the reservation update comes last so it wins on a same-address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            busy_r[clr_cnt_r] <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                busy_r[wr_addr] <= 1'b0;
            end
            if (rsv_ok_s) begin
                busy_r[rsv_addr] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] word_s;

        assign addr_s = rd_addr[g*AW +: AW];

        // Read mux: zero when not ready or for register 0
        always_comb begin
            word_s = {XLEN{1'b0}};
            if (ready_r && (addr_s != ADDR_ZERO)) begin
`ifdef REGFILE_MP_BYPASS_EN
                if (we && (wr_addr == addr_s)) begin
                    word_s = wr_data;
                end else begin
                    word_s = mem_r[addr_s];
                end
`else
                word_s = mem_r[addr_s];
`endif
            end else begin
                word_s = {XLEN{1'b0}};
            end
        end

        assign rd_data[g*XLEN +: XLEN] = word_s;
        assign rd_busy[g] = (addr_s != ADDR_ZERO) & busy_r[addr_s];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp, default 32x32x2 and a 64x16x3 instance.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // instance A: XLEN=32, NREG=32, NRD=2
    logic         a_rst, a_we, a_rsv_en, a_clr_req, a_ready;
    logic [4:0]   a_wr_addr, a_rsv_addr;
    logic [31:0]  a_wr_data;
    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;

    // instance B: XLEN=64, NREG=16, NRD=3
    logic         b_rst, b_we, b_rsv_en, b_clr_req, b_ready;
    logic [3:0]   b_wr_addr, b_rsv_addr;
    logic [63:0]  b_wr_data;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;

    regfile_mp dut_a (
        .clk(clk), .rst(a_rst), .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .clr_req(a_clr_req), .ready(a_ready)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
        .clk(clk), .rst(b_rst), .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .clr_req(b_clr_req), .ready(b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_we = 1'b0; a_rsv_en = 1'b0; a_clr_req = 1'b0;
        a_wr_addr = 5'd0; a_rsv_addr = 5'd0; a_wr_data = 32'd0; a_rd_addr = 10'd0;
        b_rst = 1'b1; b_we = 1'b0; b_rsv_en = 1'b0; b_clr_req = 1'b0;
        b_wr_addr = 4'd0; b_rsv_addr = 4'd0; b_wr_data = 64'd0; b_rd_addr = 12'd0;

        // reset state
        #3;
        chk("a_rst_ready", {63'd0, a_ready}, 64'd0);
        chk("a_rst_data", a_rd_data, 64'd0);
        chk("a_rst_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("b_rst_ready", {63'd0, b_ready}, 64'd0);
        repeat (2) tick();
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // initial sweep: A ready after 32 edges, B after 16
        for (int i = 1; i <= 32; i++) begin
            a_rd_addr = {5'(i), 5'(31 - i)};
            tick();
            chk("a_sweep_ready", {63'd0, a_ready}, (i == 32) ? 64'd1 : 64'd0);
            chk("b_sweep_ready", {63'd0, b_ready}, (i >= 16) ? 64'd1 : 64'd0);
            chk("a_sweep_data", a_rd_data, 64'd0);
        end
        for (int r = 0; r < 32; r++) begin
            a_rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk("a_post_sweep_zero", a_rd_data, 64'd0);
        end
        for (int r = 0; r < 16; r++) begin
            b_rd_addr = {4'(r), 4'(15 - r), 4'(r)};
            #1;
            chk("b_post_sweep_zero0", b_rd_data[63:0], 64'd0);
            chk("b_post_sweep_zero12", b_rd_data[191:64] == 128'd0 ? 64'd1 : 64'd0, 64'd1);
        end

        // write x5 and x0, read back
        a_we = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; tick();
        a_wr_addr = 5'd0; a_wr_data = 32'h12345678; tick();
        a_we = 1'b0; a_rd_addr = {5'd0, 5'd5}; #1;
        chk("a_x5", {32'd0, a_rd_data[31:0]}, 64'h00000000DEADBEEF);
        chk("a_x0", {32'd0, a_rd_data[63:32]}, 64'd0);
        b_we = 1'b1; b_wr_addr = 4'd5; b_wr_data = 64'hDEADBEEF0BADF00D; tick();
        b_wr_addr = 4'd0; b_wr_data = 64'h123456789ABCDEF0; tick();
        b_we = 1'b0; b_rd_addr = {4'd5, 4'd0, 4'd5}; #1;
        chk("b_x5_p0", b_rd_data[63:0], 64'hDEADBEEF0BADF00D);
        chk("b_x0_p1", b_rd_data[127:64], 64'd0);
        chk("b_x5_p2", b_rd_data[191:128], 64'hDEADBEEF0BADF00D);

        // reservations on A
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7; a_rd_addr = {5'd0, 5'd7}; #1;
        chk("a_busy_no_bypass", {62'd0, a_rd_busy}, 64'd0);
        tick();
        a_rsv_en = 1'b0; #1;
        chk("a_busy_x7_set", {62'd0, a_rd_busy}, 64'd1);
        a_we = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h1; #1;
        chk("a_busy_x7_hold", {62'd0, a_rd_busy}, 64'd1);
        tick();
        a_we = 1'b0; #1;
        chk("a_busy_x7_clr", {62'd0, a_rd_busy}, 64'd0);
        chk("a_x7_data", {32'd0, a_rd_data[31:0]}, 64'd1);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_we = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99; tick();
        a_rsv_en = 1'b0; a_we = 1'b0; a_rd_addr = {5'd9, 5'd7}; #1;
        chk("a_x9_data", {32'd0, a_rd_data[63:32]}, 64'h99);
        chk("a_x9_busy", {62'd0, a_rd_busy}, 64'd2);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd0; tick();
        a_rsv_en = 1'b0; a_rd_addr = {5'd0, 5'd9}; #1;
        chk("a_x0_busy", {62'd0, a_rd_busy}, 64'd1);

        // reservations on B
        b_rsv_en = 1'b1; b_rsv_addr = 4'd7; b_rd_addr = {4'd7, 4'd0, 4'd7}; tick();
        b_rsv_en = 1'b0; #1;
        chk("b_busy_x7_set", {61'd0, b_rd_busy}, 64'd5);
        b_we = 1'b1; b_wr_addr = 4'd7; b_wr_data = 64'h1; tick();
        b_we = 1'b0; #1;
        chk("b_busy_x7_clr", {61'd0, b_rd_busy}, 64'd0);
        b_rsv_en = 1'b1; b_rsv_addr = 4'd9; b_we = 1'b1; b_wr_addr = 4'd9;
        b_wr_data = 64'hFEDCBA9876543210; tick();
        b_rsv_en = 1'b0; b_we = 1'b0; b_rd_addr = {4'd7, 4'd9, 4'd0}; #1;
        chk("b_x9_data", b_rd_data[127:64], 64'hFEDCBA9876543210);
        chk("b_x9_busy", {61'd0, b_rd_busy}, 64'd2);

        // write/read same address in one cycle
        a_we = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h11111111; tick();
        a_wr_data = 32'hA5A5A5A5; a_rd_addr = {5'd3, 5'd3}; #1;
        chk("a_x3_same_p0", {32'd0, a_rd_data[31:0]}, BYP ? 64'hA5A5A5A5 : 64'h11111111);
        chk("a_x3_same_p1", {32'd0, a_rd_data[63:32]}, BYP ? 64'hA5A5A5A5 : 64'h11111111);
        tick();
        a_we = 1'b0; #1;
        chk("a_x3_next", a_rd_data, 64'hA5A5A5A5A5A5A5A5);
        b_we = 1'b1; b_wr_addr = 4'd3; b_wr_data = 64'h1111111111111111; tick();
        b_wr_data = 64'hA5A5A5A5A5A5A5A5; b_rd_addr = {4'd3, 4'd3, 4'd3}; #1;
        chk("b_x3_same_p0", b_rd_data[63:0], BYP ? 64'hA5A5A5A5A5A5A5A5 : 64'h1111111111111111);
        chk("b_x3_same_p2", b_rd_data[191:128], BYP ? 64'hA5A5A5A5A5A5A5A5 : 64'h1111111111111111);
        tick();
        b_we = 1'b0; #1;
        chk("b_x3_next_p1", b_rd_data[127:64], 64'hA5A5A5A5A5A5A5A5);

        // fill A, then clear with we/rsv/clr_req held during the sweep
        for (int r = 1; r < 32; r++) begin
            a_we = 1'b1; a_wr_addr = 5'(r); a_wr_data = 32'h100 + 32'(r); tick();
        end
        a_we = 1'b0; a_rd_addr = {5'd31, 5'd1}; #1;
        chk("a_fill", a_rd_data, 64'h0000011F00000101);
        a_clr_req = 1'b1; tick();
        chk("a_clr_ready_low", {63'd0, a_ready}, 64'd0);
        for (int i = 1; i <= 32; i++) begin
            a_we = 1'b1; a_wr_addr = 5'd2; a_wr_data = 32'hFFFFFFFF;
            a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
            tick();
            chk("a_clr_ready", {63'd0, a_ready}, (i == 32) ? 64'd1 : 64'd0);
        end
        a_we = 1'b0; a_rsv_en = 1'b0; a_clr_req = 1'b0;
        for (int r = 0; r < 32; r++) begin
            a_rd_addr = {5'(r), 5'(r)};
            #1;
            chk("a_clr_zero", a_rd_data, 64'd0);
            chk("a_clr_busy", {62'd0, a_rd_busy}, 64'd0);
        end

        // reset at sweep cycle 10 restarts the sweep
        a_rsv_en = 1'b1; a_rsv_addr = 5'd20; tick();
        a_rsv_en = 1'b0; a_clr_req = 1'b1; tick();
        a_clr_req = 1'b0;
        repeat (10) tick();
        a_rd_addr = {5'd20, 5'd20}; #1;
        chk("a_mid_busy_pre", {62'd0, a_rd_busy}, 64'd3);
        a_rst = 1'b1; #1;
        chk("a_mid_rst_ready", {63'd0, a_ready}, 64'd0);
        chk("a_mid_rst_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("a_mid_rst_data", a_rd_data, 64'd0);
        repeat (3) tick();
        @(negedge clk);
        a_rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("a_rst_sweep_ready", {63'd0, a_ready}, (i == 32) ? 64'd1 : 64'd0);
        end

        // clear B: 16-cycle sweep
        b_clr_req = 1'b1; tick();
        b_clr_req = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("b_clr_ready", {63'd0, b_ready}, (i == 16) ? 64'd1 : 64'd0);
        end
        b_rd_addr = {4'd3, 4'd5, 4'd9}; #1;
        chk("b_clr_p0", b_rd_data[63:0], 64'd0);
        chk("b_clr_p1", b_rd_data[127:64], 64'd0);
        chk("b_clr_p2", b_rd_data[191:128], 64'd0);
        chk("b_clr_busy", {61'd0, b_rd_busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: number of registers, power of two, at least 2; AW = log2(NREG).
REQ-003 Parameter NRD, default 2: number of independent read ports, at least 1.
REQ-004 clk  in  1: single clock; all state SHALL change on its rising edge, except on reset.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 we  in  1: write enable.
REQ-007 wr_addr  in  AW: write address.
REQ-008 wr_data  in  XLEN: write data.
REQ-009 rd_addr  in  NRD*AW: packed read addresses; port k uses bits [k*AW +: AW].
REQ-010 rd_data  out  NRD*XLEN: packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-011 rd_busy  out  NRD: port k's addressed register has a pending reservation.
REQ-012 rsv_en  in  1: reserve rsv_addr, i.e. mark a pending write.
REQ-013 rsv_addr  in  AW: reservation address.
REQ-014 clr_req  in  1: request a full clear of registers and reservations.
REQ-015 ready  out  1: high when the file accepts writes and reservations and returns stored data.

Function
REQ-016 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]] when ready = 1, and 0 when ready = 0.
REQ-017 Register 0 SHALL always read 0; writes and reservations to address 0 SHALL be ignored; rd_busy for address 0 SHALL be 0.
REQ-018 When we = 1, ready = 1 and wr_addr != 0, reg[wr_addr] SHALL take wr_data at the clock edge and its busy bit SHALL clear.
REQ-019 When rsv_en = 1, ready = 1 and rsv_addr != 0, busy[rsv_addr] SHALL set at the clock edge.
REQ-020 A write and a reservation to the same address in the same cycle: the data SHALL be written and the busy bit SHALL end up set (reservation wins).
REQ-021 rd_busy[k] SHALL equal busy[rd_addr[k]], registered state only, with no same-cycle bypass.
REQ-022 FSM states SHALL be CLEAR and READY; ready = 1 only in READY.
REQ-023 CLEAR: a counter SHALL step from 0 to NREG-1, zeroing one register and its busy bit per cycle; after the NREG-1 cycle the FSM SHALL go to READY.
REQ-024 Clearing therefore SHALL take exactly NREG cycles.
REQ-025 READY with clr_req = 1 SHALL go to CLEAR with the counter at 0; clr_req in CLEAR SHALL be ignored.
REQ-026 we, rsv_en and any write bypass SHALL be ignored in CLEAR.

Reset
REQ-027 rst = 1 SHALL immediately force: state CLEAR, counter 0, ready 0, rd_data 0, and all busy bits 0.
REQ-028 The register array itself SHALL NOT be asynchronously reset; it is zeroed by the CLEAR sweep after rst deasserts.
REQ-029 rst asserted mid-clear SHALL restart the sweep from 0.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN defined: when ready = 1, we = 1, wr_addr != 0 and rd_addr[k] = wr_addr, rd_data[k] SHALL return wr_data in the same cycle.
REQ-031 REGFILE_MP_BYPASS_EN undefined: in that case rd_data[k] SHALL return the stored (old) value, and the new value SHALL be visible from the next cycle.

Verification
REQ-032 Reset, then release at cycle 0 -> ready = 0 for exactly 32 cycles and rises at cycle 32; reads of every register give 0 during and after the sweep.
REQ-033 Write x5 = 0xDEADBEEF and x0 = 0x12345678, then read port0 = 5 and port1 = 0 -> 0xDEADBEEF and 0x00000000.
REQ-034 Reserve x7 -> rd_busy = 1 on the next cycle; write x7 = 0x1 -> busy clears the cycle after; reserve and write x9 in the same cycle -> x9 = data and busy = 1.
REQ-035 Write x3 = 0xA5A5A5A5 with both read ports on x3 in the same cycle -> 0xA5A5A5A5 with the macro defined, the prior value without it.
REQ-036 clr_req after filling x1..x31 with nonzero values -> ready low for 32 cycles, we ignored meanwhile, all registers read 0 afterwards; rst at sweep cycle 10 -> sweep restarts and ready rises 32 cycles after rst deasserts.
REQ-037 Repeat REQ-033 to REQ-035 with XLEN=64, NREG=16, NRD=3 -> identical behaviour, with the sweep taking 16 cycles.
